// File: rtl/writeback_queue.sv
// Writeback queue: buffers {rd, data} results in a circular FIFO and drains them into the
// register file write port, with a bypass lookup that returns the youngest queued value.
module writeback_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [4:0]                 in_rd,
  input  logic                       rf_hold,
  output logic [WIDTH-1:0]           rf_data,
  output logic [4:0]                 rf_location_write,
  output logic                       rf_write_enabled,
  input  logic [4:0]                 fwd_rd,
  output logic                       fwd_hit,
  output logic [WIDTH-1:0]           fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       rd_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [PW-1:0]    fwd_idx;

  assign not_empty        = (count != '0);
  assign in_ready         = (count < CW'(DEPTH));
  assign push             = in_valid && in_ready && (in_rd != 5'd0);
  assign rf_write_enabled = not_empty && !rf_hold;
  assign pop              = rf_write_enabled;

  assign rf_data           = not_empty ? data_mem[head] : '0;
  assign rf_location_write = not_empty ? rd_mem[head]   : 5'd0;

  // Entry storage is not reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest entry for that register.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if ((CW'(i) < count) && (fwd_rd != 5'd0) && (rd_mem[fwd_idx] == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a queue scoreboard tracks accepted results and
// every cycle's outputs are compared against it, alongside directed scenario checks.
module tb_writeback_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [4:0]             in_rd;
  logic                   rf_hold;
  logic [WIDTH-1:0]       rf_data;
  logic [4:0]             rf_location_write;
  logic                   rf_write_enabled;
  logic [4:0]             fwd_rd;
  logic                   fwd_hit;
  logic [WIDTH-1:0]       fwd_data;
  logic [$clog2(DEPTH):0] count;

  int     numChecks = 0;
  int     numFails  = 0;
  logic   checking  = 1'b0;
  entry_t sb[$];

  writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .rf_hold(rf_hold), .rf_data(rf_data), .rf_location_write(rf_location_write),
    .rf_write_enabled(rf_write_enabled),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [WIDTH-1:0] d,
                               input logic hold, input logic [4:0] frd);
    @(posedge clk);
    #1;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    rf_hold  = hold;
    fwd_rd   = frd;
  endtask

  // Reference behaviour: pop the head if a write is due, push if the producer is accepted.
  always @(posedge clk) begin
    logic do_pop, do_push;
    if (rst) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && !rf_hold;
      do_push = in_valid && (sb.size() < DEPTH) && (in_rd != 5'd0);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{rd: in_rd, data: in_data});
    end
  end

  always @(negedge clk) begin
    int               n;
    logic             exp_hit;
    logic [WIDTH-1:0] exp_fwd;
    if (checking) begin
      n = sb.size();
      checkOutput("count", 64'(count), 64'(n));
      checkOutput("in_ready", 64'(in_ready), 64'(n < DEPTH));
      checkOutput("rf_write_enabled", 64'(rf_write_enabled), 64'((n != 0) && !rf_hold));
      checkOutput("rf_location_write", 64'(rf_location_write), 64'(n != 0 ? sb[0].rd : 5'd0));
      checkOutput("rf_data", 64'(rf_data), 64'(n != 0 ? sb[0].data : '0));
      exp_hit = 1'b0;
      exp_fwd = '0;
      for (int i = 0; i < n; i++) begin
        if (fwd_rd != 5'd0 && sb[i].rd == fwd_rd) begin
          exp_hit = 1'b1;
          exp_fwd = sb[i].data;
        end
      end
      checkOutput("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
      checkOutput("fwd_data", 64'(fwd_data), 64'(exp_fwd));
    end
  end

  initial begin
    int budget;
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rf_hold = 1'b0; fwd_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    fwd_rd = 5'd5;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_we", 64'(rf_write_enabled), 64'd0);
    checkOutput("reset_rf_data", 64'(rf_data), 64'd0);
    checkOutput("reset_fwd_hit", 64'(fwd_hit), 64'd0);

    // Single push and its one-cycle latency
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("single_we", 64'(rf_write_enabled), 64'd1);
    checkOutput("single_loc", 64'(rf_location_write), 64'd5);
    checkOutput("single_data", 64'(rf_data), 64'h1234);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("single_count", 64'(count), 64'd0);

    // x0 results are accepted and discarded
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("x0_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("x0_count", 64'(count), 64'd0);
    checkOutput("x0_we", 64'(rf_write_enabled), 64'd0);

    // Fill under hold, then a rejected push while full, then an in-order drain
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 5'(k + 1), 32'(16'hC0 + k), 1'b1, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    @(negedge clk);
    checkOutput("full_count", 64'(count), 64'(DEPTH));
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(k == 0, 5'd9, 32'h99, 1'b0, 5'd0);
      @(negedge clk);
      checkOutput("drain_loc", 64'(rf_location_write), 64'(k + 1));
      checkOutput("drain_data", 64'(rf_data), 64'(16'hC0 + k));
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("drain_count", 64'(count), 64'd0);

    // Forwarding returns the youngest match and ignores the same-cycle input
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'hB, 1'b1, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'hC, 1'b1, 5'd3);
    @(negedge clk);
    checkOutput("fwd_youngest_hit", 64'(fwd_hit), 64'd1);
    checkOutput("fwd_youngest_data", 64'(fwd_data), 64'hB);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    @(negedge clk);
    checkOutput("fwd_x0_hit", 64'(fwd_hit), 64'd0);
    checkOutput("fwd_x0_data", 64'(fwd_data), 64'd0);
    repeat (4) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3);

    // Back-to-back pushes with no hold wrap the pointers with duplicate destinations
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 5'((k % 3) + 1), 32'(32'h500 + k), 1'b0, 5'((k % 3) + 1));
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("wrap_last_data", 64'(rf_data), 64'h509);

    // Reset mid-drain drops everything and loses the transfer in the reset cycle
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 5'(k + 10), 32'(k), 1'b1, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h77; rf_hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_count", 64'(count), 64'd0);
    checkOutput("rst_mid_we", 64'(rf_write_enabled), 64'd0);
    checkOutput("rst_mid_ready", 64'(in_ready), 64'd1);

    // Random traffic against the scoreboard
    for (int k = 0; k < 300; k++)
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom,
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 4)));

    budget = 20;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    while (count != '0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    checkOutput("final_drain", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
